// File: rtl/atom_issue_ctrl.sv
// rtl/atom_issue_ctrl.sv - round-robin issue controller for one if_else_raw stateful atom
// Drives the atom with HOLD unless a packet issues, and buffers one read/write result.
module atom_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_pkt_1,
  input  logic [31:0] req0_pkt_2,
  input  logic [31:0] req1_pkt_1,
  input  logic [31:0] req1_pkt_2,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        cfg_sel_1,
  input  logic [1:0]  cfg_sel_2,
  input  logic        cfg_sel_3,
  input  logic [1:0]  cfg_sel_4,
  input  logic        cfg_sel_5,
  input  logic [1:0]  cfg_sel_6,
  input  logic [1:0]  cfg_rel_opcode,
  input  logic [31:0] cfg_cons_1,
  input  logic [31:0] cfg_cons_2,
  input  logic [31:0] cfg_cons_3,
  output logic [31:0] atom_pkt_1,
  output logic [31:0] atom_pkt_2,
  output logic [31:0] atom_cons_1,
  output logic [31:0] atom_cons_2,
  output logic [31:0] atom_cons_3,
  output logic        atom_sel_1,
  output logic [1:0]  atom_sel_2,
  output logic        atom_sel_3,
  output logic [1:0]  atom_sel_4,
  output logic        atom_sel_5,
  output logic [1:0]  atom_sel_6,
  output logic [1:0]  atom_rel_opcode,
  input  logic [31:0] atom_read,
  input  logic [31:0] atom_write,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_src,
  output logic [31:0] res_read,
  output logic [31:0] res_write,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
);

  typedef struct packed {
    logic        sel_1;
    logic [1:0]  sel_2;
    logic        sel_3;
    logic [1:0]  sel_4;
    logic        sel_5;
    logic [1:0]  sel_6;
    logic [1:0]  rel_opcode;
    logic [31:0] cons_1;
    logic [31:0] cons_2;
    logic [31:0] cons_3;
  } cfg_t;

  // Both branches reduce to state_1 + 0, so the atom keeps its value.
  localparam cfg_t HOLD_CFG = {1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 2'd2, 2'd0, 32'd0, 32'd0, 32'd0};

  cfg_t        r_cfg;
  logic        r_last;
  logic        r_res_valid;
  logic        r_res_src;
  logic [31:0] r_res_read;
  logic [31:0] r_res_write;
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  cfg_t        w_cfg_in;
  cfg_t        w_drive;
  logic        w_free;
  logic        w_issue;
  logic        w_go;
  logic        w_gnt;

  assign w_cfg_in = {cfg_sel_1, cfg_sel_2, cfg_sel_3, cfg_sel_4, cfg_sel_5, cfg_sel_6,
                     cfg_rel_opcode, cfg_cons_1, cfg_cons_2, cfg_cons_3};

  assign w_free  = !r_res_valid || res_ready;
  assign w_issue = !cfg_valid && (req0_valid || req1_valid) && w_free;
  assign w_gnt   = (req0_valid && req1_valid) ? !r_last : req1_valid;

  // Outputs are gated while reset is asserted so they show reset values immediately.
  assign w_go       = rst_n && w_issue;
  assign cfg_ready  = rst_n && cfg_valid;
  assign req0_ready = w_go && !w_gnt;
  assign req1_ready = w_go && w_gnt;

  assign w_drive         = w_go ? r_cfg : HOLD_CFG;
  assign atom_sel_1      = w_drive.sel_1;
  assign atom_sel_2      = w_drive.sel_2;
  assign atom_sel_3      = w_drive.sel_3;
  assign atom_sel_4      = w_drive.sel_4;
  assign atom_sel_5      = w_drive.sel_5;
  assign atom_sel_6      = w_drive.sel_6;
  assign atom_rel_opcode = w_drive.rel_opcode;
  assign atom_cons_1     = w_drive.cons_1;
  assign atom_cons_2     = w_drive.cons_2;
  assign atom_cons_3     = w_drive.cons_3;
  assign atom_pkt_1      = !w_go ? 32'd0 : (w_gnt ? req1_pkt_1 : req0_pkt_1);
  assign atom_pkt_2      = !w_go ? 32'd0 : (w_gnt ? req1_pkt_2 : req0_pkt_2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg       <= HOLD_CFG;
      r_last      <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_src   <= 1'b0;
      r_res_read  <= 32'd0;
      r_res_write <= 32'd0;
      r_cnt0      <= 16'd0;
      r_cnt1      <= 16'd0;
    end else begin
      if (cfg_valid) r_cfg <= w_cfg_in;
      if (w_issue) begin
        r_res_valid <= 1'b1;
        r_res_src   <= w_gnt;
        r_res_read  <= atom_read;
        r_res_write <= atom_write;
        r_last      <= w_gnt;
        if (w_gnt) r_cnt1 <= r_cnt1 + 16'd1;
        else       r_cnt0 <= r_cnt0 + 16'd1;
      end else if (res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_src   = r_res_src;
  assign res_read  = r_res_read;
  assign res_write = r_res_write;
  assign cnt0      = r_cnt0;
  assign cnt1      = r_cnt1;

endmodule

// File: tb/tb_atom_issue_ctrl.sv
// tb/tb_atom_issue_ctrl.sv - self-checking bench for atom_issue_ctrl with a behavioural atom
// The atom and the controller reference model are both kept here.
module tb_atom_issue_ctrl;

  typedef struct packed {
    logic        sel_1;
    logic [1:0]  sel_2;
    logic        sel_3;
    logic [1:0]  sel_4;
    logic        sel_5;
    logic [1:0]  sel_6;
    logic [1:0]  rel_opcode;
    logic [31:0] cons_1;
    logic [31:0] cons_2;
    logic [31:0] cons_3;
  } cfg_t;

  localparam cfg_t HOLD = {1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 2'd2, 2'd0, 32'd0, 32'd0, 32'd0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 0, req1_valid = 0, cfg_valid = 0, res_ready = 0;
  logic req0_ready, req1_ready, cfg_ready;
  logic [31:0] req0_pkt_1 = 0, req0_pkt_2 = 0, req1_pkt_1 = 0, req1_pkt_2 = 0;
  logic cfg_sel_1 = 0, cfg_sel_3 = 0, cfg_sel_5 = 0;
  logic [1:0] cfg_sel_2 = 0, cfg_sel_4 = 0, cfg_sel_6 = 0, cfg_rel_opcode = 0;
  logic [31:0] cfg_cons_1 = 0, cfg_cons_2 = 0, cfg_cons_3 = 0;
  logic [31:0] atom_pkt_1, atom_pkt_2, atom_cons_1, atom_cons_2, atom_cons_3;
  logic atom_sel_1, atom_sel_3, atom_sel_5;
  logic [1:0] atom_sel_2, atom_sel_4, atom_sel_6, atom_rel_opcode;
  logic [31:0] atom_read, atom_write;
  logic res_valid, res_src;
  logic [31:0] res_read, res_write;
  logic [15:0] cnt0, cnt1;

  always #5 clk = ~clk;

  atom_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_pkt_1(req0_pkt_1), .req0_pkt_2(req0_pkt_2),
    .req1_pkt_1(req1_pkt_1), .req1_pkt_2(req1_pkt_2),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel_1(cfg_sel_1), .cfg_sel_2(cfg_sel_2), .cfg_sel_3(cfg_sel_3),
    .cfg_sel_4(cfg_sel_4), .cfg_sel_5(cfg_sel_5), .cfg_sel_6(cfg_sel_6),
    .cfg_rel_opcode(cfg_rel_opcode),
    .cfg_cons_1(cfg_cons_1), .cfg_cons_2(cfg_cons_2), .cfg_cons_3(cfg_cons_3),
    .atom_pkt_1(atom_pkt_1), .atom_pkt_2(atom_pkt_2),
    .atom_cons_1(atom_cons_1), .atom_cons_2(atom_cons_2), .atom_cons_3(atom_cons_3),
    .atom_sel_1(atom_sel_1), .atom_sel_2(atom_sel_2), .atom_sel_3(atom_sel_3),
    .atom_sel_4(atom_sel_4), .atom_sel_5(atom_sel_5), .atom_sel_6(atom_sel_6),
    .atom_rel_opcode(atom_rel_opcode),
    .atom_read(atom_read), .atom_write(atom_write),
    .res_valid(res_valid), .res_ready(res_ready), .res_src(res_src),
    .res_read(res_read), .res_write(res_write),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  function automatic logic [31:0] opt(input logic [31:0] s, input logic sel);
    return sel ? 32'd0 : s;
  endfunction

  function automatic logic [31:0] mux3(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [1:0] sel);
    return (sel == 2'd0) ? a : (sel == 2'd1) ? b : c;
  endfunction

  function automatic logic relop(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a != b;
      2'd1:    return a < b;
      2'd2:    return a > b;
      default: return a == b;
    endcase
  endfunction

  function automatic logic [31:0] atom_next(input logic [31:0] s, input cfg_t c,
                                            input logic [31:0] p1, input logic [31:0] p2);
    if (relop(opt(s, c.sel_1), mux3(p1, p2, c.cons_1, c.sel_2), c.rel_opcode))
      return opt(s, c.sel_3) + mux3(p1, p2, c.cons_2, c.sel_4);
    return opt(s, c.sel_5) + mux3(p1, p2, c.cons_3, c.sel_6);
  endfunction

  // Behavioural atom: commits state_1 on every edge and is never reset.
  cfg_t a_cfg;
  logic [31:0] a_state = 32'd0;
  assign a_cfg = {atom_sel_1, atom_sel_2, atom_sel_3, atom_sel_4, atom_sel_5, atom_sel_6,
                  atom_rel_opcode, atom_cons_1, atom_cons_2, atom_cons_3};
  assign atom_read  = a_state;
  assign atom_write = atom_next(a_state, a_cfg, atom_pkt_1, atom_pkt_2);
  always @(posedge clk) a_state <= atom_write;

  logic [170:0] obs_drive;
  cfg_t cfg_in;
  assign obs_drive = {a_cfg, atom_pkt_1, atom_pkt_2};
  assign cfg_in = {cfg_sel_1, cfg_sel_2, cfg_sel_3, cfg_sel_4, cfg_sel_5, cfg_sel_6,
                   cfg_rel_opcode, cfg_cons_1, cfg_cons_2, cfg_cons_3};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  cfg_t        m_cfg = HOLD;
  logic        m_last = 1'b1, m_rv = 1'b0, m_src = 1'b0;
  logic [31:0] m_rd = 0, m_wr = 0, m_state = 0;
  logic [15:0] m_cnt [2];
  logic        obs_r0 = 0, obs_r1 = 0, obs_cfg = 0;

  task automatic model_reset();
    m_cfg = HOLD; m_last = 1'b1; m_rv = 1'b0; m_src = 1'b0;
    m_rd = 0; m_wr = 0; m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  task automatic set_cfg(input cfg_t c);
    {cfg_sel_1, cfg_sel_2, cfg_sel_3, cfg_sel_4, cfg_sel_5, cfg_sel_6,
     cfg_rel_opcode, cfg_cons_1, cfg_cons_2, cfg_cons_3} = c;
  endtask

  // One clock: combinational checks at the falling edge, registered checks 1 after the rising edge.
  task automatic do_cycle();
    int win;
    logic issue;
    logic [31:0] p1, p2;
    cfg_t c_now;
    @(negedge clk);
    if (req0_valid && req1_valid) win = m_last ? 0 : 1;
    else                          win = req1_valid ? 1 : 0;
    issue = !cfg_valid && (req0_valid || req1_valid) && (!m_rv || res_ready);
    p1 = win == 1 ? req1_pkt_1 : req0_pkt_1;
    p2 = win == 1 ? req1_pkt_2 : req0_pkt_2;
    c_now = cfg_in;
    check("cfg_ready", cfg_ready, cfg_valid);
    check("req0_ready", req0_ready, issue && win == 0);
    check("req1_ready", req1_ready, issue && win == 1);
    check("atom_drive", obs_drive, issue ? {m_cfg, p1, p2} : {HOLD, 64'd0});
    obs_r0 = req0_ready; obs_r1 = req1_ready; obs_cfg = cfg_ready;
    @(posedge clk); #1;
    if (issue) begin
      m_rd = m_state;
      m_state = atom_next(m_state, m_cfg, p1, p2);
      m_wr = m_state;
      m_src = win[0];
      m_rv = 1'b1;
      m_cnt[win] = m_cnt[win] + 16'd1;
      m_last = win[0];
    end else if (res_ready) begin
      m_rv = 1'b0;
    end
    if (cfg_valid) m_cfg = c_now;
    check("res_valid", res_valid, m_rv);
    check("res_src", res_src, m_src);
    check("res_read", res_read, m_rd);
    check("res_write", res_write, m_wr);
    check("cnt0", cnt0, m_cnt[0]);
    check("cnt1", cnt1, m_cnt[1]);
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; cfg_valid = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  cfg_t c;

  initial begin
    m_cnt[0] = 0; m_cnt[1] = 0;
    do_reset();

    for (int i = 0; i < 10; i++) do_cycle();
    check("idle_sel4", atom_sel_4, 2'd2);
    check("idle_sel6", atom_sel_6, 2'd2);
    check("idle_sel35", {atom_sel_3, atom_sel_5}, 2'd0);
    check("idle_cons", {atom_cons_1, atom_cons_2, atom_cons_3}, 96'd0);
    check("idle_res_valid", res_valid, 1'b0);
    check("idle_cnt", {cnt0, cnt1}, 32'd0);

    res_ready = 1;
    c = HOLD; c.sel_3 = 1; c.sel_5 = 1;
    set_cfg(c); cfg_valid = 1; do_cycle(); cfg_valid = 0;
    req0_valid = 1; req0_pkt_1 = 32'd99; do_cycle(); req0_valid = 0;
    check("clear_write", res_write, 32'd0);
    c = HOLD; c.sel_4 = 0; c.sel_6 = 0;
    set_cfg(c); cfg_valid = 1; do_cycle(); cfg_valid = 0;
    req0_valid = 1; req0_pkt_1 = 32'd5; do_cycle();
    check("acc1", {res_read, res_write}, {32'd0, 32'd5});
    req0_pkt_1 = 32'd7; do_cycle(); req0_valid = 0;
    check("acc2", {res_read, res_write}, {32'd5, 32'd12});

    do_reset();
    res_ready = 1; req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      do_cycle();
      check("rr_grant", {obs_r0, obs_r1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      check("rr_src", res_src, i % 2);
    end
    req0_valid = 0; req1_valid = 0;
    check("rr_cnt", {cnt0, cnt1}, {16'd2, 16'd2});

    do_reset();
    res_ready = 0; req0_valid = 1; req0_pkt_1 = 32'd3;
    do_cycle();
    for (int i = 0; i < 3; i++) begin
      req0_pkt_1 = 32'd40 + i;
      do_cycle();
      check("bp_stall", obs_r0, 1'b0);
    end
    res_ready = 1; do_cycle();
    check("bp_refill", {obs_r0, res_valid}, 2'b11);
    req0_valid = 0; do_cycle();

    cfg_valid = 1; req0_valid = 1; set_cfg(HOLD); do_cycle();
    check("cfg_prio", {obs_cfg, obs_r0}, 2'b10);
    cfg_valid = 0; do_cycle();
    check("cfg_after", obs_r0, 1'b1);

    res_ready = 0; req0_valid = 1; do_cycle();
    req1_valid = 1; res_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_outs", {res_valid, res_src, res_read, res_write, cnt0, cnt1}, 98'd0);
    check("rst_ready", {req0_ready, req1_ready, cfg_ready}, 3'd0);
    check("rst_atom", obs_drive, {HOLD, 64'd0});
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    do_cycle();
    check("rst_first_grant", {obs_r0, obs_r1}, 2'b10);
    req0_valid = 0; req1_valid = 0;

    for (int i = 0; i < 3000; i++) begin
      if (!req0_valid || obs_r0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_pkt_1 = $urandom_range(0, 1000); req0_pkt_2 = $urandom_range(0, 1000);
      end
      if (!req1_valid || obs_r1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_pkt_1 = $urandom_range(0, 1000); req1_pkt_2 = $urandom_range(0, 1000);
      end
      cfg_valid = ($urandom_range(0, 9) == 0);
      if (cfg_valid) begin
        c = cfg_t'({$urandom, $urandom, $urandom, $urandom});
        c.cons_1 = $urandom_range(0, 500); c.cons_2 = $urandom_range(0, 50);
        c.cons_3 = $urandom_range(0, 50);
        set_cfg(c);
      end
      res_ready = ($urandom_range(0, 3) != 0);
      do_cycle();
    end

    do_reset();
    cfg_valid = 0; req0_valid = 0; req1_valid = 1; res_ready = 1;
    repeat (65535) do_cycle();
    check("cnt1_max", cnt1, 16'hFFFF);
    do_cycle();
    check("cnt1_wrap", cnt1, 16'h0000);
    req1_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
